sm3_message_expander: RTL and testbench

SM3_MESSAGE_EXPANDER -- requirements
Module: sm3_message_expander

---
 rtl/sm3_pkg.sv | 30 +++
 rtl/sm3_message_expander_if.sv | 26 ++
 rtl/PermutationP1.sv | 12 +
 rtl/sm3_message_expander.sv | 86 ++++++++
 tb/tb_sm3_message_expander.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm3_pkg.sv
// Shared SM3 message-expansion definitions: FSM states, widths, round count and rotate amounts.
package sm3_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int WIN_DEPTH = 16;
    localparam int ROUNDS    = 64;
    localparam int J_W       = 7;

    // Rotate amounts used by the expansion recurrence and by P1
    localparam int ROT_7  = 7;
    localparam int ROT_15 = 15;
    localparam int ROT_23 = 23;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [J_W-1:0]    rnd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam rnd_t LAST_RND = rnd_t'(ROUNDS - 1);

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/sm3_message_expander_if.sv
// Block-in / round-word-out bus of the SM3 message expander.
// Vectors are [N-1:0]; the MSB is what the SM3 text calls bit 0, so W0 sits in input_block[511:480].
interface sm3_message_expander_if;
    import sm3_pkg::*;

    logic [BLOCK_W-1:0] input_block;
    logic               input_start;
    logic               input_ready;
    logic               output_valid;
    logic [WORD_W-1:0]  output_W;
    logic [WORD_W-1:0]  output_W1;
    logic [J_W-1:0]     output_j;
    logic               output_busy;
    logic               output_done;

    modport master (
        output input_block, input_start, input_ready,
        input  output_valid, output_W, output_W1, output_j, output_busy, output_done
    );

    modport slave (
        input  input_block, input_start, input_ready,
        output output_valid, output_W, output_W1, output_j, output_busy, output_done
    );

endinterface

// File: rtl/PermutationP1.sv
// SM3 permutation P1(x) = x ^ rotl(x,15) ^ rotl(x,23); purely combinational.
// Zero latency, no flow control.
module PermutationP1
    import sm3_pkg::*;
(
    input  word_t x_i,
    output word_t y_o
);

    assign y_o = x_i ^ rotl(x_i, ROT_15) ^ rotl(x_i, ROT_23);

endmodule

// File: rtl/sm3_message_expander.sv
// Streams the 64 SM3 round word pairs (W_j, W'_j) from a 16-word sliding window; first pair valid
// the cycle after start. input_ready low freezes window, j and outputs; valid is never retracted.
module sm3_message_expander
    import sm3_pkg::*;
(
    input  logic                   input_clk,
    input  logic                   input_rst_n,
    sm3_message_expander_if.slave  bus
);

    state_t state_q, state_d;
    word_t  win_q [WIN_DEPTH];
    word_t  win_d [WIN_DEPTH];
    rnd_t   j_q, j_d;

    logic   load;
    logic   hs;
    logic   last_hs;
    word_t  p1_in;
    word_t  p1_out;
    word_t  w_new;

    assign load    = (state_q == ST_IDLE) && bus.input_start;
    assign hs      = (state_q == ST_RUN) && bus.input_ready;
    assign last_hs = hs && (j_q == LAST_RND);

    // W_(j+16) from the window: win[k] currently holds W_(j+k)
    assign p1_in = win_q[0] ^ win_q[7] ^ rotl(win_q[13], ROT_15);

    PermutationP1 u_p1 (
        .x_i (p1_in),
        .y_o (p1_out)
    );

    assign w_new = p1_out ^ rotl(win_q[3], ROT_7) ^ win_q[10];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.input_start) state_d = ST_RUN;
            ST_RUN:  if (last_hs)         state_d = ST_DONE;
            ST_DONE:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // The last handshake leaves j at 63 so the counter can never wrap inside RUN
    always_comb begin
        win_d = win_q;
        j_d   = j_q;
        if (load) begin
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_d[k] = bus.input_block[BLOCK_W - 1 - k * WORD_W -: WORD_W];
            end
            j_d = '0;
        end else if (hs && !last_hs) begin
            for (int k = 0; k < WIN_DEPTH - 1; k++) begin
                win_d[k] = win_q[k + 1];
            end
            win_d[WIN_DEPTH - 1] = w_new;
            j_d = j_q + rnd_t'(1);
        end
    end

    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            win_q   <= win_d;
        end
    end

    assign bus.output_valid = (state_q == ST_RUN);
    assign bus.output_W     = win_q[0];
    assign bus.output_W1    = win_q[0] ^ win_q[4];
    assign bus.output_j     = j_q;
    assign bus.output_busy  = (state_q != ST_IDLE);
    assign bus.output_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sm3_message_expander.sv
// Scoreboard bench for sm3_message_expander: stimulus pushes expected (j, W, W') entries, a
// negedge monitor pops them on each handshake and also checks stalls, done timing and idle gaps.
module tb_sm3_message_expander;

    typedef struct {
        int          j;
        logic [31:0] w;
        logic [31:0] w1;
    } exp_t;

    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] ALT_BLK = {
        32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
        32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f,
        32'h20212223, 32'h24252627, 32'h28292a2b, 32'h2c2d2e2f,
        32'h30313233, 32'h34353637, 32'h38393a3b, 32'h3c3d3e3f};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm3_message_expander_if bus ();

    sm3_message_expander dut (
        .input_clk   (clk),
        .input_rst_n (rst_n),
        .bus         (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    bit   toggle_rdy = 1'b0;
    bit   chk_lat = 1'b0;
    logic [31:0] obs_w  [64];
    logic [31:0] obs_w1 [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // Reference expansion in the textbook W[0..67] form
    task automatic push_expected(input logic [511:0] blk);
        logic [31:0] w [68];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
        for (int i = 16; i < 68; i++)
            w[i] = p1(w[i-16] ^ w[i-9] ^ rotl(w[i-3], 15)) ^ rotl(w[i-13], 7) ^ w[i-6];
        for (int i = 0; i < 64; i++) begin
            e.j  = i;
            e.w  = w[i];
            e.w1 = w[i] ^ w[i+4];
            sb_q.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.input_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.input_ready = toggle_rdy ? ~bus.input_ready : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, i.e. what the next rising edge will see
    initial begin
        exp_t        e;
        int          load_edge = 0;
        int          hs_cnt = 0;
        bit          after_done = 1'b0;
        logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0;
        logic [31:0] prev_w = '0, prev_w1 = '0;
        logic [6:0]  prev_j = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_busy  = 1'b0;
                after_done = 1'b0;
            end else begin
                if (after_done) begin
                    check("idle_after_done_busy", bus.output_busy, 0);
                    check("idle_after_done_done", bus.output_done, 0);
                    after_done = 1'b0;
                end
                if (bus.output_busy && !prev_busy) begin
                    load_edge = cyc;
                    hs_cnt    = 0;
                end
                if (prev_valid && !prev_ready) begin
                    check("stall_valid", bus.output_valid, 1);
                    check("stall_W",  bus.output_W,  prev_w);
                    check("stall_W1", bus.output_W1, prev_w1);
                    check("stall_j",  {25'd0, bus.output_j}, {25'd0, prev_j});
                end
                if (bus.output_valid && bus.input_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: handshake at j=%0d with no expected entry", bus.output_j);
                    end else begin
                        e = sb_q.pop_front();
                        check("seq_j",  {25'd0, bus.output_j}, e.j);
                        check("seq_W",  bus.output_W,  e.w);
                        check("seq_W1", bus.output_W1, e.w1);
                    end
                    if (bus.output_j < 7'd64) begin
                        obs_w[bus.output_j]  = bus.output_W;
                        obs_w1[bus.output_j] = bus.output_W1;
                    end
                    hs_cnt++;
                end
                if (bus.output_done) begin
                    check("done_hs_count", hs_cnt, 64);
                    check("done_valid", bus.output_valid, 0);
                    check("done_busy",  bus.output_busy, 1);
                    // counts rising edges from the load edge to the edge that samples done
                    if (chk_lat) check("done_latency", cyc + 1 - load_edge, 65);
                    after_done = 1'b1;
                end
                prev_valid = bus.output_valid;
                prev_ready = bus.input_ready;
                prev_busy  = bus.output_busy;
                prev_w     = bus.output_W;
                prev_w1    = bus.output_W1;
                prev_j     = bus.output_j;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [511:0] blk);
        bus.input_block = blk;
        bus.input_start = 1'b1;
        push_expected(blk);
        tick();
        bus.input_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!bus.output_done && n < budget) begin
            tick();
            n++;
        end
        if (!bus.output_done) begin
            checks++;
            errors++;
            $display("FAIL %s: output_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_j(input string name, input int jj, input int budget);
        int n = 0;
        while (!(bus.output_valid && bus.output_j == 7'(jj)) && n < budget) begin
            tick();
            n++;
        end
        if (!(bus.output_valid && bus.output_j == 7'(jj))) begin
            checks++;
            errors++;
            $display("FAIL %s: j=%0d not reached within %0d cycles (j=%0d)", name, jj, budget, bus.output_j);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 64; i++) begin
            obs_w[i]  = 'x;
            obs_w1[i] = 'x;
        end
    endtask

    task automatic check_abc(input string tag);
        check({tag, "_W0"},   obs_w[0],   32'h61626380);
        check({tag, "_W1_0"}, obs_w1[0],  32'h61626380);
        check({tag, "_W12"},  obs_w[12],  32'h00000000);
        check({tag, "_W1_12"},obs_w1[12], 32'h9092e200);
        check({tag, "_W16"},  obs_w[16],  32'h9092e200);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, bus.output_valid, 0);
        check({tag, "_busy"},  bus.output_busy, 0);
        check({tag, "_done"},  bus.output_done, 0);
        check({tag, "_j"},     {25'd0, bus.output_j}, 0);
        check({tag, "_W"},     bus.output_W, 0);
        check({tag, "_W1"},    bus.output_W1, 0);
    endtask

    initial begin
        logic [511:0] blk;
        bus.input_block = '0;
        bus.input_start = 1'b0;
        clear_obs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // "abc" with ready held high
        chk_lat = 1'b1;
        start_block(ABC_BLK);
        wait_done("abc_done", 200);
        tick();
        check_abc("abc");

        // ready toggling every cycle
        chk_lat = 1'b0;
        toggle_rdy = 1'b1;
        clear_obs();
        start_block(ABC_BLK);
        wait_done("toggle_done", 400);
        toggle_rdy = 1'b0;
        tick();
        check_abc("toggle");

        // start pulsed mid-run and block changed after the load edge
        chk_lat = 1'b1;
        clear_obs();
        start_block(ABC_BLK);
        bus.input_block = {16{32'hdeadbeef}};
        wait_j("ign_wait_j10", 10, 100);
        bus.input_start = 1'b1;
        bus.input_block = ALT_BLK;
        tick();
        bus.input_start = 1'b0;
        wait_done("ign_done", 200);
        tick();
        check_abc("ignore");

        // reset in the middle of a block, then a clean restart
        start_block(ABC_BLK);
        wait_j("rst_wait_j30", 30, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        clear_obs();
        start_block(ABC_BLK);
        wait_done("restart_done", 200);
        tick();
        check_abc("restart");

        // back-to-back blocks with start in the idle cycle after done
        start_block(ALT_BLK);
        wait_done("b2b_first_done", 200);
        tick();
        check("b2b_gap_busy", bus.output_busy, 0);
        clear_obs();
        start_block(ABC_BLK);
        check("b2b_second_busy", bus.output_busy, 1);
        wait_done("b2b_second_done", 200);
        tick();
        check_abc("b2b");

        // random blocks against the reference model
        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < 16; k++) blk[32 * k +: 32] = $urandom();
            start_block(blk);
            wait_done("rand_done", 200);
            tick();
        end

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
